dcache_tag_arbiter: RTL



---
 rtl/std_cache_pkg.sv | 40 ++++
 rtl/dcache_rr_pick.sv | 43 ++++
 rtl/dcache_tag_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/std_cache_pkg.sv
// Shared data-cache types: arbitration mode, lock state, default SRAM line and byte-enable layouts.
package std_cache_pkg;

   // Arbitration policy for the tag/data SRAM arbiter
   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // Bus-lock state of the tag arbiter
   typedef enum logic {
      LK_IDLE   = 1'b0,
      LK_LOCKED = 1'b1
   } lock_state_e;

   localparam int unsigned DCACHE_TAG_WIDTH  = 44;
   localparam int unsigned DCACHE_LINE_WIDTH = 32;

   // One way of a cache line as stored in the SRAMs
   typedef struct packed {
      logic [DCACHE_TAG_WIDTH-1:0]  tag;
      logic [DCACHE_LINE_WIDTH-1:0] data;
      logic                         valid;
      logic                         dirty;
   } cache_line_t;

   // Byte enables matching cache_line_t
   typedef struct packed {
      logic [DCACHE_TAG_WIDTH/8-1:0]  tag;
      logic [DCACHE_LINE_WIDTH/8-1:0] data;
      logic                           vldrty;
   } cl_be_t;

   // Next round-robin pointer after a grant to port idx; port 0 never moves the pointer
   function automatic int unsigned rr_advance(input int unsigned idx, input int unsigned nr_ports);
      if (idx == 0) return 0;
      return (idx >= nr_ports - 1) ? 1 : idx + 1;
   endfunction

endpackage

// File: rtl/dcache_rr_pick.sv
// Round-robin pick: first non-excluded requester at or after the pointer, wrapping over all WIDTH bits.
module dcache_rr_pick #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]         i_req,
   input  logic [WIDTH-1:0]         i_excl,
   input  logic [$clog2(WIDTH)-1:0] i_ptr,
   output logic [WIDTH-1:0]         o_gnt,
   output logic [$clog2(WIDTH)-1:0] o_idx,
   output logic                     o_valid
);

   localparam int unsigned IDX_W  = $clog2(WIDTH);
   localparam int unsigned CAND_W = IDX_W + 1;

   logic [WIDTH-1:0]  w_req;
   logic [CAND_W-1:0] w_cand;
   logic              w_found;

   assign w_req = i_req & ~i_excl;

   // Scan candidates starting at the pointer, taking the first eligible one
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_cand = {1'b0, i_ptr} + CAND_W'(i);
         if (w_cand >= CAND_W'(WIDTH)) begin
            w_cand = w_cand - CAND_W'(WIDTH);
         end
         if (!w_found && w_req[w_cand[IDX_W-1:0]]) begin
            w_found                   = 1'b1;
            o_valid                   = 1'b1;
            o_idx                     = w_cand[IDX_W-1:0];
            o_gnt[w_cand[IDX_W-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dcache_tag_arbiter.sv
// N-port arbiter and tag comparator in front of the way-organised L1 data-cache SRAMs.
// Port 0 is the miss handler. Supports fixed or round-robin arbitration, per-port bus
// locking for atomic sequences, optional port-0 preemption and a lock watchdog.
module dcache_tag_arbiter
   import std_cache_pkg::*;
#(
   parameter int unsigned NR_PORTS      = 5,
   parameter int unsigned SET_ASSOC     = 8,
   parameter int unsigned INDEX_WIDTH   = 12,
   parameter int unsigned TAG_WIDTH     = 44,
   parameter type         line_t        = cache_line_t,
   parameter type         be_t          = cl_be_t,
   parameter arb_mode_e   ARB_MODE      = ARB_FIXED,
   parameter bit          PORT0_PREEMPT = 1'b1,
   parameter int unsigned MAX_LOCK      = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]   req_i,
   input  logic [NR_PORTS-1:0]                  lock_i,
   input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0] addr_i,
   input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]   tag_i,
   input  logic [NR_PORTS-1:0]                  we_i,
   input  line_t [NR_PORTS-1:0]                 wdata_i,
   input  be_t [NR_PORTS-1:0]                   be_i,
   output logic [NR_PORTS-1:0]                  gnt_o,
   output line_t [SET_ASSOC-1:0]                rdata_o,
   output logic [SET_ASSOC-1:0]                 hit_way_o,
   output logic                                 lock_timeout_o,
   output logic [SET_ASSOC-1:0]                 req_o,
   output logic [INDEX_WIDTH-1:0]               addr_o,
   output logic                                 we_o,
   output line_t                                wdata_o,
   output be_t                                  be_o,
   input  line_t [SET_ASSOC-1:0]                rdata_i
);

   localparam int unsigned SEL_W = $clog2(NR_PORTS);
   localparam int unsigned LC_W  = $clog2(MAX_LOCK + 1);

   // Lock FSM and arbitration state
   lock_state_e       r_state;
   lock_state_e       w_state_nxt;
   logic [SEL_W-1:0]  r_lk;
   logic [SEL_W-1:0]  w_lk_nxt;
   logic [LC_W-1:0]   r_lc;
   logic [LC_W-1:0]   w_lc_nxt;
   logic [SEL_W-1:0]  r_rr;
   logic [SEL_W-1:0]  w_rr_nxt;

   // Hit-compare pipeline: who was granted last cycle and whether it wrote
   logic [SEL_W-1:0]  r_sel;
   logic              r_v;
   logic              r_we;

   // Arbitration helpers
   logic [NR_PORTS-1:0] w_req_any;
   logic                w_force;
   logic [NR_PORTS-1:0] w_excl;
   logic [SEL_W-1:0]    w_ptr;
   logic [NR_PORTS-1:0] w_pick_gnt;
   logic [SEL_W-1:0]    w_pick_idx;
   logic                w_pick_valid;
   logic                w_free;

   // Resulting grant of this cycle
   logic                w_gnt_valid;
   logic [SEL_W-1:0]    w_gnt_idx;
   logic [NR_PORTS-1:0] w_gnt_oh;
   logic                w_timeout;

   // A port requests when any bit of its way mask is set
   always_comb begin
      w_req_any = '0;
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
         w_req_any[p] = |req_i[p];
      end
   end

   // Watchdog expiry releases the lock and keeps the old owner out of this arbitration
   assign w_force = (r_state == LK_LOCKED) && (r_lc == LC_W'(MAX_LOCK));
   assign w_excl  = w_force ? (NR_PORTS'(1) << r_lk) : '0;

   // Fixed mode scans from port 0; RR mode starts at port 0 only when it is eligible
   assign w_ptr = ((ARB_MODE == ARB_RR) && !(w_req_any[0] && !w_excl[0])) ? r_rr : '0;

   dcache_rr_pick #(
      .WIDTH (NR_PORTS)
   ) u_pick (
      .i_req   (w_req_any),
      .i_excl  (w_excl),
      .i_ptr   (w_ptr),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   // Lock FSM next state and grant decision
   always_comb begin
      w_state_nxt = r_state;
      w_lk_nxt    = r_lk;
      w_lc_nxt    = r_lc;
      w_rr_nxt    = r_rr;
      w_gnt_valid = 1'b0;
      w_gnt_idx   = '0;
      w_gnt_oh    = '0;
      w_timeout   = 1'b0;
      w_free      = 1'b0;

      case (r_state)
         LK_IDLE: begin
            w_free = 1'b1;
         end
         LK_LOCKED: begin
            if (w_force) begin
               w_timeout   = 1'b1;
               w_state_nxt = LK_IDLE;
               w_lc_nxt    = '0;
               w_free      = 1'b1;
            end else if (PORT0_PREEMPT && (r_lk != '0) && w_req_any[0]) begin
               // Miss handler steals one cycle; lock, counter and pointer stay put
               w_gnt_valid = 1'b1;
               w_gnt_idx   = '0;
               w_gnt_oh    = NR_PORTS'(1);
            end else if (w_req_any[r_lk]) begin
               w_gnt_valid = 1'b1;
               w_gnt_idx   = r_lk;
               w_gnt_oh    = NR_PORTS'(1) << r_lk;
               if (lock_i[r_lk]) begin
                  w_lc_nxt = r_lc + LC_W'(1);
               end else begin
                  w_state_nxt = LK_IDLE;
                  w_lc_nxt    = '0;
               end
            end else begin
               // Owner walked away: drop the lock, nobody is granted this cycle
               w_state_nxt = LK_IDLE;
               w_lc_nxt    = '0;
            end
         end
         default: begin
            w_state_nxt = LK_IDLE;
            w_lc_nxt    = '0;
         end
      endcase

      if (w_free && w_pick_valid) begin
         w_gnt_valid = 1'b1;
         w_gnt_idx   = w_pick_idx;
         w_gnt_oh    = w_pick_gnt;
         if ((ARB_MODE == ARB_RR) && (w_pick_idx != '0)) begin
            w_rr_nxt = SEL_W'(rr_advance(32'(w_pick_idx), NR_PORTS));
         end
         if (lock_i[w_pick_idx]) begin
            w_state_nxt = LK_LOCKED;
            w_lk_nxt    = w_pick_idx;
            w_lc_nxt    = LC_W'(1);
         end
      end
   end

   // Lock FSM and round-robin pointer registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= LK_IDLE;
         r_lk    <= '0;
         r_lc    <= '0;
         r_rr    <= SEL_W'(1);
      end else begin
         r_state <= w_state_nxt;
         r_lk    <= w_lk_nxt;
         r_lc    <= w_lc_nxt;
         r_rr    <= w_rr_nxt;
      end
   end

   // Remember last cycle's grant for the late-tag compare
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sel <= '0;
         r_v   <= 1'b0;
         r_we  <= 1'b0;
      end else begin
         r_sel <= w_gnt_idx;
         r_v   <= w_gnt_valid;
         r_we  <= w_gnt_valid & we_i[w_gnt_idx];
      end
   end

   // Mux the winner onto the SRAM side; idle bus is driven to zero
   always_comb begin
      req_o   = '0;
      addr_o  = '0;
      we_o    = 1'b0;
      wdata_o = '0;
      be_o    = '0;
      if (w_gnt_valid) begin
         req_o   = req_i[w_gnt_idx];
         addr_o  = addr_i[w_gnt_idx];
         we_o    = we_i[w_gnt_idx];
         wdata_o = wdata_i[w_gnt_idx];
         be_o    = be_i[w_gnt_idx];
      end
   end

   // Per-way tag compare against the late tag of last cycle's reader
   always_comb begin
      hit_way_o = '0;
      for (int unsigned j = 0; j < SET_ASSOC; j++) begin
         hit_way_o[j] = r_v & ~r_we & rdata_i[j].valid & (rdata_i[j].tag == tag_i[r_sel]);
      end
   end

   assign gnt_o          = w_gnt_oh;
   assign lock_timeout_o = w_timeout;
   assign rdata_o        = rdata_i;

endmodule
